gx4000_palette_unit: RTL and testbench
======================================

# gx4000_palette_unit

Plus-mode palette stage for the GX4000 video path. It keeps a 32-entry, 12-bit shadow of the ASIC palette RAM (pens 0–15, border, sprite pens 1–15). The shadow is kept current by snooping CPU writes and by a bulk reload engine that reads ASIC RAM. On each pixel strobe it turns a pen index into 4-bit-per-channel RGB, which feeds the GX4000 video output/mixing stage directly downstream.

## Interface
- PAL_BASE, 14'h2400: ASIC RAM byte offset of palette entry 0 (CPU address 0x6400).
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- plus_en  in  1  1 = output Plus palette colours; 0 = CPC passthrough.
- snoop_wr  in  1  CPU write strobe into ASIC RAM, one cycle per byte.
- snoop_addr  in  14  ASIC RAM byte offset of the CPU write.
- snoop_din  in  8  CPU write data.
- reload  in  1  one-cycle request to re-copy all 64 palette bytes from ASIC RAM.
- ram_rd  out  1  read strobe to ASIC RAM.
- ram_addr  out  14  read address.
- ram_q  in  8  read data, valid exactly one cycle after ram_rd.
- reload_busy  out  1  reload engine active.
- reload_done  out  1  one-cycle pulse when a reload completes.
- pix_en  in  1  pixel clock enable; the pipeline advances only when high.
- pix_blank  in  1  blanking; forces black.
- pix_border  in  1  border area; selects entry 16.
- pix_sprite  in  1  sprite pixel; selects entry 16+pix_pen (pen 0 treated as ink path).
- pix_pen  in  5  ink or sprite pen index (ink uses [3:0]).
- cpc_r / cpc_g / cpc_b  in  2 each  CPC gate-array colour for passthrough.
- r_out / g_out / b_out  out  4 each  registered colour outputs.

## Operation
- Entry n occupies bytes PAL_BASE+2n and PAL_BASE+2n+1.
  - Even byte = {R[3:0], B[3:0]}.
  - Odd byte bits [3:0] = G; bits [7:4] are ignored.
- Snoop: on snoop_wr with snoop_addr in [PAL_BASE, PAL_BASE+63], update the matching half of entry (snoop_addr−PAL_BASE)>>1. Writes outside the range are ignored. No byte pairing is needed; each byte updates independently.
- Reload FSM has three states: IDLE, REQ, CAP; it carries a 6-bit byte counter i.
  - IDLE: reload=1 → clear i, go to REQ.
  - REQ: ram_rd=1, ram_addr=PAL_BASE+i → go to CAP.
  - CAP: write ram_q into byte i of the shadow.
    - If i=63: go to IDLE and pulse reload_done.
    - Otherwise: i+1, go to REQ.
  - reload asserted while busy is ignored.
  - ram_rd is 0 and ram_addr holds its last value outside REQ.
- Collision rule: if a snoop write and a CAP write hit the same shadow byte in the same cycle, the snoop value is kept. A snoop to a different byte and a CAP write both take effect.
- Pixel pipeline, two stages, both gated by pix_en:
  - S1 latches the selected entry index plus blank and plus_en flags:
    - border → 16;
    - sprite with pix_pen[3:0]≠0 → 16+pix_pen[3:0];
    - otherwise ink → pix_pen[3:0].
  - S1 also latches cpc_r/g/b.
  - S2 drives the outputs:
    - blank → 0,0,0;
    - plus_en=0 → each channel = {c,c} (2→4-bit replicate; e.g. 2'b10 → 4'hA);
    - otherwise shadow[index] as R, G, B.
- Shadow read in S2 is read-before-write: a snoop/CAP update in the same cycle is visible from the next pix_en onward.

## Timing
- Reset (async assert, synchronous-safe deassert):
  - outputs and shadow all 0;
  - FSM in IDLE with i=0;
  - reload_busy=0, reload_done=0, ram_rd=0, ram_addr=0.
- Reset mid-reload aborts the reload; the shadow is cleared and reload_done is not pulsed.
- Pixel latency: colour appears on r/g/b_out at the clock edge of the 2nd pix_en after input presentation. Outputs hold between strobes.
- Reload timing: reload at edge T → first REQ cycle T+1 → 128 cycles of REQ/CAP → reload_done high during cycle T+129. reload_busy is high during cycles T+1..T+128.
- Snoop latency: the shadow is updated at the edge that samples snoop_wr. The next pixel S2 read sees the new value.

## Test plan
- Reset: hold reset_n=0 mid-reload → all outputs 0, busy 0; after release, a pix_en pair with pen 5 and plus_en=1 → RGB 0,0,0.
- Snoop: write 0x6400+10 ← 8'hF3 and +11 ← 8'h07 (offsets 0x240A/0x240B), then present pen 5 → r=F, g=7, b=3 after 2 pix_en.
- Reload: preload RAM model bytes 0x2400..0x243F with i^8'h5A, pulse reload → 64 reads at 0x2400+i, done pulse exactly 129 cycles after the pulse, shadow matches byte-for-byte. A second reload mid-run is ignored.
- Collision: during reload, snoop 8'h11 to the byte the FSM captures that cycle → shadow byte = 8'h11.
- Selection: border=1 with entry16={R=2,G=4,B=6} → 2,4,6. sprite pen 3 → entry 19. sprite pen 0 → ink pen 0. blank=1 → 0,0,0.
- Passthrough: plus_en=0, cpc=(2'b01,2'b10,2'b11) → r=5, g=A, b=F.

Source files
------------

// File: rtl/gx4000_palette_unit.sv
`default_nettype none
// ============================================================================
// Module   : gx4000_palette_unit
// Purpose  : Plus-mode palette shadow (snoop + bulk reload) and 2-stage
//            pen-to-RGB pixel pipeline feeding the GX4000 video mixer.
// Revision : 1.0 - initial release
// ============================================================================
module gx4000_palette_unit #(
  parameter logic [13:0] PAL_BASE = 14'h2400
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        plus_en,
  input  logic        snoop_wr,
  input  logic [13:0] snoop_addr,
  input  logic [7:0]  snoop_din,
  input  logic        reload,
  output logic        ram_rd,
  output logic [13:0] ram_addr,
  input  logic [7:0]  ram_q,
  output logic        reload_busy,
  output logic        reload_done,
  input  logic        pix_en,
  input  logic        pix_blank,
  input  logic        pix_border,
  input  logic        pix_sprite,
  input  logic [4:0]  pix_pen,
  input  logic [1:0]  cpc_r,
  input  logic [1:0]  cpc_g,
  input  logic [1:0]  cpc_b,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [13:0] addr_hold_q, addr_hold_d;
  logic        done_q, done_d;
  logic        cap_we;

  // Even bytes hold {R,B}; odd bytes only keep G in their low nibble.
  logic [7:0]  even_q [32];
  logic [7:0]  even_d [32];
  logic [3:0]  odd_q  [32];
  logic [3:0]  odd_d  [32];

  logic [13:0] snoop_off;
  logic        snoop_hit;

  logic [4:0]  sel_idx;
  logic [4:0]  idx_q, idx_d;
  logic        blank_q, blank_d;
  logic        plus_q, plus_d;
  logic [1:0]  cr_q, cr_d, cg_q, cg_d, cb_q, cb_d;
  logic [3:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  logic        unused_pen_msb;
  assign unused_pen_msb = pix_pen[4];

  // Reload engine
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cap_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reload) begin
          cnt_d   = 6'd0;
          state_d = ST_REQ;
        end
      end
      ST_REQ:  state_d = ST_CAP;
      ST_CAP: begin
        cap_we = 1'b1;
        if (cnt_q == 6'd63) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 6'd1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ram_rd      = (state_q == ST_REQ);
  assign ram_addr    = ram_rd ? (PAL_BASE + {8'd0, cnt_q}) : addr_hold_q;
  assign addr_hold_d = ram_addr;
  assign reload_busy = (state_q != ST_IDLE);
  assign reload_done = done_q;

  assign snoop_off = snoop_addr - PAL_BASE;
  assign snoop_hit = snoop_wr && (snoop_off[13:6] == 8'd0);

  // Snoop is applied after the capture so it wins a same-byte collision.
  always_comb begin
    even_d = even_q;
    odd_d  = odd_q;
    if (cap_we) begin
      if (cnt_q[0]) odd_d[cnt_q[5:1]]  = ram_q[3:0];
      else          even_d[cnt_q[5:1]] = ram_q;
    end
    if (snoop_hit) begin
      if (snoop_off[0]) odd_d[snoop_off[5:1]]  = snoop_din[3:0];
      else              even_d[snoop_off[5:1]] = snoop_din;
    end
  end

  assign sel_idx = pix_border                          ? 5'd16 :
                   (pix_sprite && pix_pen[3:0] != 4'd0) ? {1'b1, pix_pen[3:0]} :
                                                          {1'b0, pix_pen[3:0]};

  always_comb begin
    idx_d   = idx_q;
    blank_d = blank_q;
    plus_d  = plus_q;
    cr_d    = cr_q;
    cg_d    = cg_q;
    cb_d    = cb_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    if (pix_en) begin
      idx_d   = sel_idx;
      blank_d = pix_blank;
      plus_d  = plus_en;
      cr_d    = cpc_r;
      cg_d    = cpc_g;
      cb_d    = cpc_b;
      if (blank_q) begin
        r_d = 4'd0;
        g_d = 4'd0;
        b_d = 4'd0;
      end else if (!plus_q) begin
        r_d = {cr_q, cr_q};
        g_d = {cg_q, cg_q};
        b_d = {cb_q, cb_q};
      end else begin
        r_d = even_q[idx_q][7:4];
        g_d = odd_q[idx_q];
        b_d = even_q[idx_q][3:0];
      end
    end
  end

  assign r_out = r_q;
  assign g_out = g_q;
  assign b_out = b_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      addr_hold_q <= 14'd0;
      done_q      <= 1'b0;
      for (int k = 0; k < 32; k++) begin
        even_q[k] <= 8'd0;
        odd_q[k]  <= 4'd0;
      end
      idx_q   <= 5'd0;
      blank_q <= 1'b0;
      plus_q  <= 1'b0;
      cr_q    <= 2'd0;
      cg_q    <= 2'd0;
      cb_q    <= 2'd0;
      r_q     <= 4'd0;
      g_q     <= 4'd0;
      b_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_hold_q <= addr_hold_d;
      done_q      <= done_d;
      even_q      <= even_d;
      odd_q       <= odd_d;
      idx_q       <= idx_d;
      blank_q     <= blank_d;
      plus_q      <= plus_d;
      cr_q        <= cr_d;
      cg_q        <= cg_d;
      cb_q        <= cb_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gx4000_palette_unit.sv
`default_nettype none
// Testbench for gx4000_palette_unit: randomized stimulus against a
// cycle-level behavioural model, plus literal colour expectations.
module tb_gx4000_palette_unit;
  localparam int PAL_BASE = 'h2400;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        plus_en = 1'b0;
  logic        snoop_wr = 1'b0;
  logic [13:0] snoop_addr = 14'd0;
  logic [7:0]  snoop_din = 8'd0;
  logic        reload = 1'b0;
  logic        ram_rd;
  logic [13:0] ram_addr;
  logic [7:0]  ram_q = 8'd0;
  logic        reload_busy, reload_done;
  logic        pix_en = 1'b0, pix_blank = 1'b0, pix_border = 1'b0, pix_sprite = 1'b0;
  logic [4:0]  pix_pen = 5'd0;
  logic [1:0]  cpc_r = 2'd0, cpc_g = 2'd0, cpc_b = 2'd0;
  logic [3:0]  r_out, g_out, b_out;

  gx4000_palette_unit dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .plus_en(plus_en),
    .snoop_wr(snoop_wr), .snoop_addr(snoop_addr), .snoop_din(snoop_din),
    .reload(reload), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_q(ram_q),
    .reload_busy(reload_busy), .reload_done(reload_done),
    .pix_en(pix_en), .pix_blank(pix_blank), .pix_border(pix_border),
    .pix_sprite(pix_sprite), .pix_pen(pix_pen),
    .cpc_r(cpc_r), .cpc_g(cpc_g), .cpc_b(cpc_b),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ASIC RAM: palette window only, answers one cycle after ram_rd.
  logic [7:0] mem [64];
  always @(posedge clk_sys) if (ram_rd) ram_q <= mem[ram_addr[5:0]];

  // Behavioural model: shadow bytes, reload timeline, pixel pipeline.
  logic [7:0] m_sh [64];
  int  m_idx, rl_k, j;
  bit  rl_active, m_blank, m_plus;
  logic [1:0] m_cr, m_cg, m_cb;
  int  e_r, e_g, e_b, e_addr;
  bit  e_busy, e_done, e_rd;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 64; k++) m_sh[k] = 8'd0;
      rl_active = 0; rl_k = 0; m_idx = 0; m_blank = 0; m_plus = 0;
      m_cr = 0; m_cg = 0; m_cb = 0;
      e_r = 0; e_g = 0; e_b = 0; e_addr = 0;
      e_busy = 0; e_done = 0; e_rd = 0;
    end else begin
      if (pix_en) begin
        if (m_blank) begin
          e_r = 0; e_g = 0; e_b = 0;
        end else if (!m_plus) begin
          e_r = m_cr * 5; e_g = m_cg * 5; e_b = m_cb * 5;
        end else begin
          e_r = m_sh[2*m_idx] >> 4;
          e_b = m_sh[2*m_idx] & 'hF;
          e_g = m_sh[2*m_idx+1] & 'hF;
        end
        if (pix_border) m_idx = 16;
        else if (pix_sprite && (pix_pen % 16) != 0) m_idx = 16 + pix_pen % 16;
        else m_idx = pix_pen % 16;
        m_blank = pix_blank; m_plus = plus_en;
        m_cr = cpc_r; m_cg = cpc_g; m_cb = cpc_b;
      end
      e_done = 0;
      if (rl_active) begin
        if (rl_k % 2 == 0) begin
          j = (rl_k - 2) / 2;
          m_sh[j] = mem[j];
          if (rl_k == 128) begin
            rl_active = 0;
            e_done = 1;
          end
        end
        rl_k++;
      end else if (reload) begin
        rl_active = 1;
        rl_k = 1;
      end
      if (snoop_wr && snoop_addr >= PAL_BASE && snoop_addr <= PAL_BASE + 63)
        m_sh[snoop_addr - PAL_BASE] = snoop_din;
      e_busy = rl_active;
      e_rd = rl_active && (rl_k % 2 == 1);
      if (e_rd) e_addr = PAL_BASE + (rl_k - 1) / 2;
    end
  end

  always @(negedge clk_sys) begin
    #1;
    if (chk_en) begin
      chk("r_out", r_out, e_r);
      chk("g_out", g_out, e_g);
      chk("b_out", b_out, e_b);
      chk("reload_busy", reload_busy, e_busy);
      chk("reload_done", reload_done, e_done);
      chk("ram_rd", ram_rd, e_rd);
      chk("ram_addr", ram_addr, e_addr);
    end
  end

  task automatic pix_pair(input bit bd, input bit sp, input logic [4:0] pen,
                          input bit bl, input bit pl,
                          input logic [1:0] cr, input logic [1:0] cg, input logic [1:0] cb);
    @(negedge clk_sys);
    pix_border = bd; pix_sprite = sp; pix_pen = pen; pix_blank = bl;
    plus_en = pl; cpc_r = cr; cpc_g = cg; cpc_b = cb; pix_en = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    pix_en = 1'b0;
    #2;
  endtask

  task automatic snoop(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    snoop_wr = 1'b1; snoop_addr = a; snoop_din = d;
    @(negedge clk_sys);
    snoop_wr = 1'b0;
  endtask

  task automatic expect_rgb(input string name, input int r, input int g, input int b);
    chk({name, ".r"}, r_out, r);
    chk({name, ".g"}, g_out, g);
    chk({name, ".b"}, b_out, b);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!reload_done && k < 400) begin
      @(negedge clk_sys); #2; k++;
    end
    chk({name, ".done_seen"}, reload_done, 1);
  endtask

  initial begin
    int k;
    bit found;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(negedge clk_sys);
    chk_en = 1'b1;
    @(negedge clk_sys);
    reset_n = 1'b1;
    #2;
    expect_rgb("reset", 0, 0, 0);
    chk("reset.busy", reload_busy, 0);
    chk("reset.addr", ram_addr, 0);

    // Reload with latency measurement and an ignored second request.
    @(negedge clk_sys);
    reload = 1'b1;
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
      if (k == 1 || k == 41) reload = 1'b0;
      if (k == 40) reload = 1'b1;
      #2;
      if (k == 1) chk("reload.first_addr", ram_addr, PAL_BASE);
    end while (!reload_done && k < 300);
    chk("reload.latency", k, 129);
    @(negedge clk_sys); #2;
    chk("reload.busy_after", reload_busy, 0);

    pix_pair(0, 0, 5'd1, 0, 1, 0, 0, 0);
    expect_rgb("reload.pen1", 5, 9, 8);
    for (int p = 0; p < 32; p++) pix_pair(p >= 16, p >= 16, 5'(p % 16), 0, 1, 0, 0, 0);

    snoop(14'h240A, 8'hF3);
    snoop(14'h240B, 8'h07);
    pix_pair(0, 0, 5'd5, 0, 1, 0, 0, 0);
    expect_rgb("snoop.pen5", 'hF, 7, 3);

    snoop(14'h2420, 8'h26);
    snoop(14'h2421, 8'h04);
    pix_pair(1, 0, 5'd7, 0, 1, 0, 0, 0);
    expect_rgb("border", 2, 4, 6);
    snoop(14'h2426, 8'h9C);
    snoop(14'h2427, 8'hF5);
    pix_pair(0, 1, 5'd3, 0, 1, 0, 0, 0);
    expect_rgb("sprite3", 9, 5, 'hC);
    pix_pair(0, 1, 5'h10, 0, 1, 0, 0, 0);
    expect_rgb("sprite0_ink0", 5, 'hB, 'hA);
    snoop(14'h23FF, 8'hFF);
    snoop(14'h2440, 8'hFF);
    pix_pair(0, 0, 5'd5, 1, 1, 0, 0, 0);
    expect_rgb("blank", 0, 0, 0);
    pix_pair(0, 0, 5'd5, 0, 0, 2'b01, 2'b10, 2'b11);
    expect_rgb("passthrough", 5, 'hA, 'hF);

    // Collision: snoop the byte being captured in the same cycle.
    @(negedge clk_sys);
    reload = 1'b1;
    @(negedge clk_sys);
    reload = 1'b0;
    found = 0;
    k = 0;
    while (!found && k < 300) begin
      #2;
      if (ram_rd && ram_addr == 14'h2406) found = 1;
      else begin @(negedge clk_sys); k++; end
    end
    chk("collision.req_seen", found, 1);
    snoop(14'h2406, 8'h11);
    wait_done("collision");
    pix_pair(0, 0, 5'd3, 0, 1, 0, 0, 0);
    expect_rgb("collision.pen3", 1, 'hD, 1);

    // Reset in the middle of a reload.
    @(negedge clk_sys);
    reload = 1'b1;
    @(negedge clk_sys);
    reload = 1'b0;
    repeat (20) @(negedge clk_sys);
    reset_n = 1'b0;
    #2;
    chk("midreset.busy", reload_busy, 0);
    chk("midreset.rd", ram_rd, 0);
    chk("midreset.addr", ram_addr, 0);
    expect_rgb("midreset", 0, 0, 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    pix_pair(0, 0, 5'd5, 0, 1, 0, 0, 0);
    expect_rgb("postreset.pen5", 0, 0, 0);

    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_sys);
      reload = ($urandom_range(0, 149) == 0);
      snoop_wr = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0, 1: snoop_addr = 14'(PAL_BASE + $urandom_range(0, 63));
        2:    snoop_addr = ($urandom_range(0, 1) == 0) ? 14'h23FF : 14'h2440;
        default: snoop_addr = 14'($urandom);
      endcase
      snoop_din = 8'($urandom);
      pix_en = ($urandom_range(0, 1) == 0);
      pix_blank = ($urandom_range(0, 9) == 0);
      pix_border = ($urandom_range(0, 7) == 0);
      pix_sprite = ($urandom_range(0, 2) == 0);
      pix_pen = 5'($urandom);
      plus_en = ($urandom_range(0, 5) != 0);
      cpc_r = 2'($urandom); cpc_g = 2'($urandom); cpc_b = 2'($urandom);
    end
    @(negedge clk_sys);
    reload = 1'b0; snoop_wr = 1'b0; pix_en = 1'b0;
    repeat (300) @(negedge clk_sys);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
